// File: rtl/lc4_mp_pkg.sv
// Shared types and constants for the LC4 multi-precision shift sequencer.
package lc4_mp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } state_t;

  // SDR2: result = {carry, r2[W-1:1]}
  localparam logic [19:0] SDR2_INSN = 20'h0A030;

  localparam int LC4_WORD_SIZE = 64;
  localparam int LC4_DADDR     = 4;

endpackage

// File: rtl/lc4_mp_shift_seq.sv
// Multi-precision right shift by one bit through the LC4 SDR2 op, top limb first, 2 cycles/limb + 1.
// Define LC4_MP_SHIFT_COUNT_EN to add i_shamt, which repeats the whole pass shamt times.
module lc4_mp_shift_seq
  import lc4_mp_pkg::*;
#(
  parameter int WORD_SIZE = LC4_WORD_SIZE,
  parameter int DADDR     = LC4_DADDR,
  parameter int INSN      = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [DADDR-1:0]     i_base,
  input  logic [DADDR:0]       i_nlimbs,
  input  logic                 i_cin,
`ifdef LC4_MP_SHIFT_COUNT_EN
  input  logic [5:0]           i_shamt,
`endif
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_cout,
  output logic                 o_rd_en,
  output logic [DADDR-1:0]     o_rd_addr,
  input  logic [WORD_SIZE-1:0] i_rd_data,
  output logic                 o_wr_en,
  output logic [DADDR-1:0]     o_wr_addr,
  output logic [WORD_SIZE-1:0] o_wr_data,
  output logic [INSN:0]        o_alu_insn,
  output logic [WORD_SIZE-1:0] o_alu_r2data,
  output logic                 o_alu_carry,
  input  logic [WORD_SIZE-1:0] i_alu_result
);

  state_t           state, state_nxt;
  logic [DADDR-1:0] cur;
  logic [DADDR:0]   remaining;
  logic             carry_reg;
  logic [DADDR-1:0] top_addr;
  logic             start_empty;
  logic             last_limb;
  logic             final_pass;

  // Top limb address; nlimbs == 2^DADDR folds to base-1, which is the same limb mod 2^DADDR.
  assign top_addr  = i_base + i_nlimbs[DADDR-1:0] - DADDR'(1);
  assign last_limb = (remaining == (DADDR+1)'(1));

`ifdef LC4_MP_SHIFT_COUNT_EN
  logic [5:0]       passes;
  logic [DADDR-1:0] top_reg;
  logic [DADDR:0]   nlimbs_reg;
  logic             cin_reg;

  assign start_empty = (i_nlimbs == '0) || (i_shamt == '0);
  assign final_pass  = (passes == 6'd1);
`else
  assign start_empty = (i_nlimbs == '0);
  assign final_pass  = 1'b1;
`endif

  always_comb begin
    state_nxt    = state;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    o_rd_en      = 1'b0;
    o_rd_addr    = '0;
    o_wr_en      = 1'b0;
    o_wr_addr    = '0;
    o_wr_data    = '0;
    o_alu_insn   = '0;
    o_alu_r2data = '0;
    o_alu_carry  = 1'b0;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_nxt = start_empty ? DONE : READ;
      end
      READ: begin
        o_rd_en   = 1'b1;
        o_rd_addr = cur;
        state_nxt = EXEC;
      end
      EXEC: begin
        o_alu_insn   = (INSN+1)'(SDR2_INSN);
        o_alu_r2data = i_rd_data;
        o_alu_carry  = carry_reg;
        o_wr_en      = 1'b1;
        o_wr_addr    = cur;
        o_wr_data    = i_alu_result;
        state_nxt    = (last_limb && final_pass) ? DONE : READ;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      remaining <= '0;
      carry_reg <= 1'b0;
      o_cout    <= 1'b0;
`ifdef LC4_MP_SHIFT_COUNT_EN
      passes     <= '0;
      top_reg    <= '0;
      nlimbs_reg <= '0;
      cin_reg    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (i_start) begin
            carry_reg <= i_cin;
            cur       <= top_addr;
            remaining <= i_nlimbs;
`ifdef LC4_MP_SHIFT_COUNT_EN
            passes     <= i_shamt;
            top_reg    <= top_addr;
            nlimbs_reg <= i_nlimbs;
            cin_reg    <= i_cin;
`endif
          end
        end
        EXEC: begin
          if (!last_limb) begin
            cur       <= cur - DADDR'(1);
            remaining <= remaining - (DADDR+1)'(1);
            carry_reg <= i_rd_data[0];
          end
`ifdef LC4_MP_SHIFT_COUNT_EN
          // Another pass: restart at the top limb with the original carry-in.
          else if (!final_pass) begin
            passes    <= passes - 6'd1;
            cur       <= top_reg;
            remaining <= nlimbs_reg;
            carry_reg <= cin_reg;
          end
`endif
          else begin
            remaining <= remaining - (DADDR+1)'(1);
            carry_reg <= i_rd_data[0];
          end
        end
        DONE: o_cout <= carry_reg;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lc4_mp_shift_seq.sv
// Bench for lc4_mp_shift_seq: limb memory + SDR2 ALU models, bignum reference model, directed and random ops.
module tb_lc4_mp_shift_seq;

  localparam int NL = 16;

  logic        clk = 1'b0;
  logic        rst, i_start, i_cin;
  logic [3:0]  i_base;
  logic [4:0]  i_nlimbs;
`ifdef LC4_MP_SHIFT_COUNT_EN
  logic [5:0]  i_shamt;
`endif
  logic        o_busy, o_done, o_cout, o_rd_en, o_wr_en, o_alu_carry;
  logic [3:0]  o_rd_addr, o_wr_addr;
  logic [63:0] i_rd_data, o_wr_data, o_alu_r2data, i_alu_result;
  logic [19:0] o_alu_insn;

  logic [63:0] mem [NL];
  logic [63:0] img [NL];
  logic [67:0] wr_log [$];
  int          rd_cnt = 0;
  logic        tb_we;
  logic [3:0]  tb_wa;
  logic [63:0] tb_wd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lc4_mp_shift_seq dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_base(i_base), .i_nlimbs(i_nlimbs), .i_cin(i_cin),
`ifdef LC4_MP_SHIFT_COUNT_EN
    .i_shamt(i_shamt),
`endif
    .o_busy(o_busy), .o_done(o_done), .o_cout(o_cout),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_alu_insn(o_alu_insn), .o_alu_r2data(o_alu_r2data), .o_alu_carry(o_alu_carry),
    .i_alu_result(i_alu_result)
  );

  // The ALU's SDR2 operation
  assign i_alu_result = (o_alu_insn == 20'h0A030) ? {o_alu_carry, o_alu_r2data[63:1]} : 64'h0;

  always @(posedge clk) begin
    if (o_rd_en) begin
      i_rd_data <= mem[o_rd_addr];
      rd_cnt    <= rd_cnt + 1;
    end
    if (tb_we) mem[tb_wa] <= tb_wd;
    else if (o_wr_en) begin
      mem[o_wr_addr] <= o_wr_data;
      wr_log.push_back({o_wr_addr, o_wr_data});
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_img();
    for (int i = 0; i < NL; i++) begin
      @(negedge clk);
      tb_we = 1'b1; tb_wa = 4'(i); tb_wd = img[i];
    end
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic rand_img();
    for (int i = 0; i < NL; i++) img[i] = {$urandom, $urandom};
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ctl"}, {o_busy, o_done, o_cout, o_rd_en, o_wr_en, o_alu_carry, o_rd_addr, o_wr_addr, o_alu_insn}, 0);
    chk({tag, "_dat"}, {o_wr_data, o_alu_r2data}, 0);
  endtask

  // One operation checked against a bignum view of the operand: X >> 1 with cin entering the top bit.
  task automatic run_op(input string tag, input int base, input int n, input bit cin, input int shamt, input bit poke);
    logic [1023:0] x;
    logic [63:0]   exp_mem [NL];
    logic [67:0]   exp_w [$];
    bit            exp_cout;
    int            passes, w0, r0, cyc, bad, mm, exp_cyc;
    for (int i = 0; i < NL; i++) exp_mem[i] = mem[i];
`ifdef LC4_MP_SHIFT_COUNT_EN
    passes = shamt;
`else
    passes = 1;
`endif
    exp_cout = cin;
    if (n > 0) begin
      for (int p = 0; p < passes; p++) begin
        x = '0;
        for (int i = 0; i < n; i++) x[64*i +: 64] = exp_mem[(base + i) % NL];
        exp_cout = x[0];
        x = x >> 1;
        x[64*n-1] = cin;
        for (int i = n - 1; i >= 0; i--) begin
          exp_mem[(base + i) % NL] = x[64*i +: 64];
          exp_w.push_back({4'((base + i) % NL), x[64*i +: 64]});
        end
      end
    end
    exp_cyc = (n == 0 || passes == 0) ? 1 : 2 * n * passes + 1;

    @(negedge clk);
    i_start = 1'b1; i_base = 4'(base); i_nlimbs = 5'(n); i_cin = cin;
`ifdef LC4_MP_SHIFT_COUNT_EN
    i_shamt = 6'(shamt);
`endif
    w0 = wr_log.size(); r0 = rd_cnt;
    @(posedge clk); #1;
    i_start = 1'b0;
    cyc = 1; bad = 0;
    while (o_done !== 1'b1 && cyc < 400) begin
      if (o_wr_en && (o_alu_insn !== 20'h0A030 || o_rd_en)) bad++;
      if (poke) begin
        i_start = (cyc == 2);
        if (cyc == 2) begin i_base = i_base + 4'd5; i_nlimbs = 5'd1; i_cin = ~cin; end
      end
      @(posedge clk); #1;
      cyc++;
    end
    i_start = 1'b0;
    chk({tag, "_done_cycle"}, cyc, exp_cyc);
    chk({tag, "_busy_at_done"}, o_busy, 1'b1);
    @(posedge clk); #1;
    chk({tag, "_done_pulse_busy"}, {o_done, o_busy}, 2'b00);
    chk({tag, "_cout"}, o_cout, exp_cout);
    chk({tag, "_wr_count"}, wr_log.size() - w0, exp_w.size());
    for (int k = 0; k < exp_w.size(); k++)
      if (w0 + k < wr_log.size()) chk({tag, "_write"}, wr_log[w0 + k], exp_w[k]);
    chk({tag, "_rd_count"}, rd_cnt - r0, (n == 0) ? 0 : n * passes);
    chk({tag, "_exec_insn"}, bad, 0);
    mm = 0;
    for (int i = 0; i < NL; i++) if (mem[i] !== exp_mem[i]) mm++;
    chk({tag, "_mem"}, mm, 0);
  endtask

  initial begin
    int w0;
    rst = 1'b1; i_start = 1'b0; i_base = '0; i_nlimbs = '0; i_cin = 1'b0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
`ifdef LC4_MP_SHIFT_COUNT_EN
    i_shamt = 6'd1;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk) rst = 1'b0;

    // Single limb
    rand_img(); img[3] = 64'h0000_0000_0000_0003; load_img();
    run_op("single", 3, 1, 1'b1, 1, 1'b0);
    chk("single_mem3", mem[3], 64'h8000_0000_0000_0001);

    // Two limbs
    rand_img(); img[1] = 64'h1; img[0] = 64'h0; load_img();
    run_op("two", 0, 2, 1'b0, 1, 1'b0);
    chk("two_mem", {mem[1], mem[0]}, {64'h0, 64'h8000_0000_0000_0000});

    // Empty operation
    run_op("n0", 7, 0, 1'b1, 1, 1'b0);

    // Wrap-around
    rand_img(); img[0] = 64'h2; img[15] = 64'h5; load_img();
    run_op("wrap", 15, 2, 1'b0, 1, 1'b0);
    chk("wrap_mem", {mem[0], mem[15]}, {64'h1, 64'h2});

    // Start while busy is ignored
    rand_img(); load_img();
    run_op("busy", 2, 4, 1'b1, 1, 1'b1);

    // Full memory, with and without wrap
    rand_img(); load_img();
    run_op("full0", 0, 16, 1'b1, 1, 1'b0);
    rand_img(); load_img();
    run_op("full5", 5, 16, 1'b0, 1, 1'b0);

    // Reset during the second EXEC
    rand_img(); load_img();
    @(negedge clk);
    i_start = 1'b1; i_base = 4'd0; i_nlimbs = 5'd4; i_cin = 1'b1;
    w0 = wr_log.size();
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_exec_wr", {o_wr_en, o_wr_addr}, {1'b1, 4'd2});
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle_outputs("rst_mid");
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_mid_wr_count", wr_log.size() - w0, 2);
    chk("rst_mid_idle", {o_busy, o_rd_en, o_wr_en}, 3'b000);
    chk("rst_mid_mem", {mem[3], mem[2]}, {1'b1, img[3][63:1], img[3][0], img[2][63:1]});

`ifdef LC4_MP_SHIFT_COUNT_EN
    rand_img(); img[4] = 64'hF; load_img();
    run_op("shamt3", 4, 1, 1'b0, 3, 1'b0);
    chk("shamt3_mem", mem[4], 64'h1);
    run_op("shamt0", 4, 3, 1'b1, 0, 1'b0);
`endif

    for (int t = 0; t < 16; t++) begin
      rand_img(); load_img();
`ifdef LC4_MP_SHIFT_COUNT_EN
      run_op("rand", $urandom_range(0, 15), $urandom_range(0, 16), 1'($urandom), $urandom_range(0, 3), 1'($urandom));
`else
      run_op("rand", $urandom_range(0, 15), $urandom_range(0, 16), 1'($urandom), 1, 1'($urandom));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
